// File: rtl/pe_fwd_if.sv
// Bus bundle for one pe_fwd: load ports, run control, neighbour
// forwarding handshakes and the final-result strobe.
interface pe_fwd_if #(
    parameter int DATA_WIDTH = 16,
    parameter int INST_WIDTH = 14,
    parameter int ITER_WIDTH = 8
);
    logic                    inst_in_v;
    logic [INST_WIDTH-1:0]   inst_in;
    logic                    din_pe_v;
    logic [2*DATA_WIDTH-1:0] din_pe;
    logic                    start;
    logic [ITER_WIDTH-1:0]   iter_num;
    logic                    din_tx_v;
    logic [2*DATA_WIDTH-1:0] din_tx;
    logic                    din_tx_rdy;
    logic                    dout_tx_v;
    logic [2*DATA_WIDTH-1:0] dout_tx;
    logic                    dout_tx_rdy;
    logic                    dout_pe_v;
    logic [2*DATA_WIDTH-1:0] dout_pe;
    logic                    busy;

    // PE side
    modport slave (
        input  inst_in_v, inst_in, din_pe_v, din_pe, start, iter_num,
        input  din_tx_v, din_tx, dout_tx_rdy,
        output din_tx_rdy, dout_tx_v, dout_tx, dout_pe_v, dout_pe, busy
    );

    // Controller / neighbour side
    modport master (
        output inst_in_v, inst_in, din_pe_v, din_pe, start, iter_num,
        output din_tx_v, din_tx, dout_tx_rdy,
        input  din_tx_rdy, dout_tx_v, dout_tx, dout_pe_v, dout_pe, busy
    );
endinterface

// File: rtl/pe_fwd.sv
// Processing element: local instruction memory, complex register file,
// single-cycle complex ALU (add/sub/Q-format multiply) and a stalling
// valid/ready forward to the next PE. Runs the loaded program iter_num times.
module pe_fwd #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_NUM    = 16,
    parameter int INST_DEPTH = 16,
    parameter int ITER_WIDTH = 8
) (
    input logic       clk,
    input logic       rst_n,
    pe_fwd_if.slave   bus
);
    localparam int RA         = $clog2(REG_NUM);
    localparam int IA         = $clog2(INST_DEPTH);
    localparam int PA         = IA + 1;
    localparam int INST_WIDTH = 2 + 3 * RA;
    localparam int CW         = 2 * DATA_WIDTH;
    localparam int PW         = 2 * DATA_WIDTH + 1;
    localparam logic [PA-1:0] DEPTH_P = PA'(INST_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, XFER} state_t;
    typedef enum logic [1:0] {OP_CADD = 2'b00, OP_CSUB = 2'b01, OP_CMUL = 2'b10, OP_FWD = 2'b11} op_t;

    state_t state, state_nxt;

    logic [CW-1:0]         rf   [REG_NUM];
    logic [INST_WIDTH-1:0] imem [INST_DEPTH];

    logic [PA-1:0]         iptr, pc;
    logic [RA-1:0]         dptr;
    logic [ITER_WIDTH-1:0] iter_cnt, iter_lat;

    logic [INST_WIDTH-1:0] inst;
    op_t                   op;
    logic [RA-1:0]         rd, rs1, rs2;
    logic [CW-1:0]         src1, src2, alu_res, wr_data;
    logic                  pc_wrap, last;
    logic                  start_go, inst_we, data_we, alu_we, fwd_go, rx_we, retire;

    logic signed [DATA_WIDTH-1:0] ar, ai, br, bi;
    logic signed [PW-1:0]         xr, xi, yr, yi, pre, pim;
    logic [DATA_WIDTH-1:0]        mre, mim;

    assign inst    = imem[pc[IA-1:0]];
    assign op      = op_t'(inst[INST_WIDTH-1 -: 2]);
    assign rd      = inst[3*RA-1:2*RA];
    assign rs1     = inst[2*RA-1:RA];
    assign rs2     = inst[RA-1:0];
    assign src1    = rf[rs1];
    assign src2    = rf[rs2];
    assign pc_wrap = (pc == iptr - PA'(1));
    assign last    = pc_wrap && (iter_cnt == iter_lat - ITER_WIDTH'(1));
    assign wr_data = (state == XFER) ? bus.din_tx : alu_res;
    assign bus.busy = (state != IDLE);

    // Complex ALU: per-component wrapping add/sub, full-precision multiply
    // scaled back by DATA_WIDTH-1 with an arithmetic shift.
    always_comb begin
        ar  = src1[CW-1:DATA_WIDTH];
        ai  = src1[DATA_WIDTH-1:0];
        br  = src2[CW-1:DATA_WIDTH];
        bi  = src2[DATA_WIDTH-1:0];
        xr  = PW'(ar);
        xi  = PW'(ai);
        yr  = PW'(br);
        yi  = PW'(bi);
        pre = xr * yr - xi * yi;
        pim = xr * yi + xi * yr;
        mre = DATA_WIDTH'(pre >>> (DATA_WIDTH - 1));
        mim = DATA_WIDTH'(pim >>> (DATA_WIDTH - 1));
        case (op)
            OP_CADD: alu_res = {ar + br, ai + bi};
            OP_CSUB: alu_res = {ar - br, ai - bi};
            OP_CMUL: alu_res = {mre, mim};
            default: alu_res = src1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_nxt = state;
        start_go  = 1'b0;
        inst_we   = 1'b0;
        data_we   = 1'b0;
        alu_we    = 1'b0;
        fwd_go    = 1'b0;
        rx_we     = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                inst_we = bus.inst_in_v && (iptr != DEPTH_P);
                data_we = bus.din_pe_v;
                if (bus.start && (iptr != '0) && (bus.iter_num != '0)) begin
                    start_go  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (op == OP_FWD) begin
                    fwd_go    = 1'b1;
                    state_nxt = XFER;
                end else begin
                    alu_we = 1'b1;
                    retire = 1'b1;
                end
            end
            XFER: begin
                // Each side counts as done once its handshake has happened,
                // either earlier (flag already dropped) or on this edge.
                rx_we  = bus.din_tx_v && bus.din_tx_rdy;
                retire = (!bus.dout_tx_v || bus.dout_tx_rdy) &&
                         (!bus.din_tx_rdy || bus.din_tx_v);
            end
            default: state_nxt = IDLE;
        endcase
        if (retire) state_nxt = last ? IDLE : RUN;
    end

    // Pointers, iteration control, forwarding handshakes and result output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iptr           <= '0;
            dptr           <= '0;
            pc             <= '0;
            iter_cnt       <= '0;
            iter_lat       <= '0;
            bus.dout_tx    <= '0;
            bus.dout_tx_v  <= 1'b0;
            bus.din_tx_rdy <= 1'b0;
            bus.dout_pe_v  <= 1'b0;
            bus.dout_pe    <= '0;
        end else begin
            bus.dout_pe_v <= 1'b0;
            if (inst_we) iptr <= iptr + PA'(1);
            if (data_we) dptr <= dptr + RA'(1);
            if ((state == IDLE) && bus.start) dptr <= '0;
            if (start_go) begin
                iter_lat <= bus.iter_num;
                iter_cnt <= '0;
                pc       <= '0;
            end
            if (fwd_go) begin
                bus.dout_tx    <= src1;
                bus.dout_tx_v  <= 1'b1;
                bus.din_tx_rdy <= 1'b1;
            end
            if (state == XFER) begin
                if (bus.dout_tx_v && bus.dout_tx_rdy) bus.dout_tx_v <= 1'b0;
                if (rx_we) bus.din_tx_rdy <= 1'b0;
            end
            if (retire) begin
                if (pc_wrap) begin
                    pc       <= '0;
                    iter_cnt <= iter_cnt + ITER_WIDTH'(1);
                end else begin
                    pc <= pc + PA'(1);
                end
                if (last) begin
                    bus.dout_pe_v <= 1'b1;
                    // R0 bypass when the retiring instruction targets R0
                    bus.dout_pe   <= (rd == '0) ? wr_data : rf[0];
                end
            end
        end
    end

    // Instruction memory and register file writes (contents survive reset)
    always_ff @(posedge clk) begin
        if (inst_we) imem[iptr[IA-1:0]] <= bus.inst_in;
        if (data_we)              rf[dptr] <= bus.din_pe;
        else if (alu_we || rx_we) rf[rd]   <= wr_data;
    end
endmodule

// File: tb/tb_pe_fwd.sv
// Scoreboard bench for pe_fwd: a sequential instruction-level model predicts
// results, forwarded words and completion cycles; monitor processes compare.
module tb_pe_fwd;
    localparam int DW = 16;
    localparam int IW = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    pe_fwd_if #(.DATA_WIDTH(DW), .INST_WIDTH(IW), .ITER_WIDTH(8)) bus ();

    pe_fwd #(.DATA_WIDTH(DW), .REG_NUM(16), .INST_DEPTH(16), .ITER_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          run_s = -1;
    int          run_done = -1;
    int          tx_hold = 0;
    int          rx_hold = 0;
    int          tx_wait = 0;
    int          rx_wait = 0;
    bit          armed = 0;
    bit          rx_took = 0;
    bit          prev_v = 0;
    logic [31:0] prev_tx;
    bit          use_fixed_rx = 0;
    logic [31:0] fixed_rx;
    logic [31:0] last_res;
    exp_t        e;

    exp_t        exp_res_q[$];
    logic [31:0] exp_tx_q[$];
    logic [31:0] rx_src_q[$];
    logic [13:0] imem_m[17];
    logic [31:0] rf_init[16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [13:0] enc(input int op, input int rd, input int rs1, input int rs2);
        logic [1:0] o;
        logic [3:0] d, s1, s2;
        o = 2'(op); d = 4'(rd); s1 = 4'(rs1); s2 = 4'(rs2);
        return {o, d, s1, s2};
    endfunction

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        longint ar, ai, br, bi, re, im;
        logic [63:0] ure, uim;
        ar = longint'($signed(a[31:16]));
        ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16]));
        bi = longint'($signed(b[15:0]));
        case (op)
            0: begin re = ar + br; im = ai + bi; end
            1: begin re = ar - br; im = ai - bi; end
            default: begin
                re = (ar * br - ai * bi) >>> 15;
                im = (ar * bi + ai * br) >>> 15;
            end
        endcase
        ure = re;
        uim = im;
        return {ure[15:0], uim[15:0]};
    endfunction

    // Executes the program instruction by instruction; returns R0 and cycle cost.
    task automatic model_run(input int p, input int iters, output logic [31:0] res, output int cost);
        logic [31:0] r[16];
        logic [13:0] ins;
        logic [31:0] v;
        int op;
        r = rf_init;
        cost = 0;
        for (int it = 0; it < iters; it++) begin
            for (int k = 0; k < p; k++) begin
                ins = imem_m[k];
                op = int'(ins[13:12]);
                if (op == 3) begin
                    exp_tx_q.push_back(r[ins[7:4]]);
                    v = use_fixed_rx ? fixed_rx : $urandom;
                    rx_src_q.push_back(v);
                    r[ins[11:8]] = v;
                    cost += 2 + ((tx_hold > rx_hold) ? tx_hold : rx_hold);
                end else begin
                    r[ins[11:8]] = ref_alu(op, r[ins[7:4]], r[ins[3:0]]);
                    cost += 1;
                end
            end
        end
        res = r[0];
    endtask

    // Monitor: busy window, results with completion cycle, forwarded words
    always @(negedge clk) begin
        if (rst_n && armed) begin
            chk("busy", {31'b0, bus.busy}, {31'b0, (cyc > run_s && cyc < run_done)});
            if (bus.dout_pe_v) begin
                if (exp_res_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
                else begin
                    e = exp_res_q.pop_front();
                    chk("result", bus.dout_pe, e.val);
                    chk("done_cycle", cyc, e.cyc);
                end
            end
            if (bus.dout_tx_v && prev_v) chk("tx_stable", bus.dout_tx, prev_tx);
            if (bus.dout_tx_v && bus.dout_tx_rdy) begin
                if (exp_tx_q.size() == 0) chk("spurious_tx", 32'd1, 32'd0);
                else chk("tx_data", bus.dout_tx, exp_tx_q.pop_front());
            end
            if (bus.din_tx_v && bus.din_tx_rdy) rx_took = 1;
            prev_v  = bus.dout_tx_v && !bus.dout_tx_rdy;
            prev_tx = bus.dout_tx;
        end else begin
            prev_v = 0;
        end
    end

    // Next-PE partner: withholds ready for tx_hold cycles of valid
    initial begin
        bus.dout_tx_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.dout_tx_v) begin
                if (tx_wait >= tx_hold) bus.dout_tx_rdy = 1'b1;
                else begin bus.dout_tx_rdy = 1'b0; tx_wait++; end
            end else begin
                bus.dout_tx_rdy = 1'b0;
                tx_wait = 0;
            end
        end
    end

    // Previous-PE partner: presents the next queued word after rx_hold cycles
    initial begin
        bus.din_tx_v = 1'b0;
        bus.din_tx   = '0;
        forever begin
            @(posedge clk); #1;
            if (rx_took) begin
                rx_took = 0;
                if (rx_src_q.size() > 0) rx_src_q.delete(0);
                rx_wait = 0;
            end
            if (bus.din_tx_rdy && rx_src_q.size() > 0) begin
                if (rx_wait >= rx_hold) begin
                    bus.din_tx_v = 1'b1;
                    bus.din_tx   = rx_src_q[0];
                end else begin
                    bus.din_tx_v = 1'b0;
                    bus.din_tx   = $urandom;
                    rx_wait++;
                end
            end else begin
                bus.din_tx_v = 1'b0;
                bus.din_tx   = $urandom;
                rx_wait = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs;
        bus.inst_in_v = 1'b0; bus.inst_in = '0;
        bus.din_pe_v  = 1'b0; bus.din_pe  = '0;
        bus.start     = 1'b0; bus.iter_num = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        exp_res_q.delete();
        exp_tx_q.delete();
        rx_src_q.delete();
        rx_took  = 0;
        run_s    = -1;
        run_done = -1;
        rst_n    = 1'b0;
        #1;
        chk("rst_busy",    {31'b0, bus.busy},       32'd0);
        chk("rst_done_v",  {31'b0, bus.dout_pe_v},  32'd0);
        chk("rst_tx_v",    {31'b0, bus.dout_tx_v},  32'd0);
        chk("rst_rx_rdy",  {31'b0, bus.din_tx_rdy}, 32'd0);
        chk("rst_dout_pe", bus.dout_pe,             32'd0);
        chk("rst_dout_tx", bus.dout_tx,             32'd0);
        tick(); tick();
        rst_n = 1'b1;
        armed = 1;
        tick();
    endtask

    task automatic rand_rf;
        for (int i = 0; i < 16; i++) rf_init[i] = $urandom;
    endtask

    task automatic launch(input int nload, input int iters, input bit zstart, input bit junk,
                          input bit use_ovr, input logic [31:0] ovr, output int cost);
        logic [31:0] res;
        int p, s;
        for (int i = 0; i < 16; i++) begin
            bus.din_pe_v = 1'b1; bus.din_pe = rf_init[i]; tick();
        end
        bus.din_pe_v = 1'b0;
        for (int i = 0; i < nload; i++) begin
            bus.inst_in_v = 1'b1; bus.inst_in = imem_m[i]; tick();
        end
        bus.inst_in_v = 1'b0;
        if (zstart) begin
            bus.start = 1'b1; bus.iter_num = '0; tick();
            bus.start = 1'b0; tick(); tick();
            chk("zero_iter_busy", {31'b0, bus.busy}, 32'd0);
        end
        p = (nload > 16) ? 16 : nload;
        model_run(p, iters, res, cost);
        if (use_ovr) res = ovr;
        last_res = res;
        s = cyc;
        exp_res_q.push_back('{val: res, cyc: s + cost + 1});
        run_s    = s;
        run_done = s + cost + 1;
        bus.start = 1'b1; bus.iter_num = 8'(iters);
        tick();
        bus.start = 1'b0;
        if (junk) begin
            for (int j = 0; j < ((cost < 4) ? cost : 4); j++) begin
                bus.inst_in_v = 1'b1; bus.inst_in = 14'($urandom);
                bus.din_pe_v  = 1'b1; bus.din_pe  = $urandom;
                bus.start     = 1'b1; bus.iter_num = 8'($urandom_range(1, 255));
                tick();
            end
            idle_inputs();
        end
    endtask

    task automatic await_done(input int cost);
        for (int k = 0; k < cost + 30; k++) begin
            if (exp_res_q.size() == 0) break;
            tick();
        end
        chk("done_timeout", exp_res_q.size(), 32'd0);
        exp_res_q.delete();
        chk("tx_leftover", exp_tx_q.size(), 32'd0);
        exp_tx_q.delete();
        tick(); tick(); tick();
        chk("pe_hold", bus.dout_pe, last_res);
    endtask

    task automatic run_case(input int nload, input int iters, input bit zstart, input bit junk,
                            input bit use_ovr, input logic [31:0] ovr, input int th, input int rh);
        int cost;
        do_reset();
        tx_hold = th;
        rx_hold = rh;
        launch(nload, iters, zstart, junk, use_ovr, ovr, cost);
        await_done(cost);
    endtask

    initial begin
        int cost;
        idle_inputs();
        tick();

        // Q15 multiply: 0.5 * 0.5
        rand_rf(); rf_init[1] = 32'h4000_0000; rf_init[2] = 32'h4000_0000;
        imem_m[0] = enc(2, 0, 1, 2);
        run_case(1, 1, 0, 0, 1, 32'h2000_0000, 0, 0);

        // Wrapping add over three iterations
        rand_rf(); rf_init[0] = 32'h7FFF_0000; rf_init[1] = 32'h0001_0001;
        imem_m[0] = enc(0, 0, 0, 1);
        run_case(1, 3, 0, 0, 1, 32'h8002_0003, 0, 0);

        // Wrapping subtract
        rand_rf(); rf_init[1] = 32'h8000_0000; rf_init[2] = 32'h0001_0000;
        imem_m[0] = enc(1, 0, 1, 2);
        run_case(1, 1, 0, 0, 1, 32'h7FFF_0000, 0, 0);

        // (0.5+0.5j)(0.5-0.5j)
        rand_rf(); rf_init[1] = 32'h4000_4000; rf_init[2] = 32'h4000_C000;
        imem_m[0] = enc(2, 0, 1, 2);
        run_case(1, 1, 0, 0, 1, 32'h4000_0000, 0, 0);

        // Forward with stalls on both sides, then minimal two-cycle forward
        rand_rf(); rf_init[1] = 32'h0011_0022;
        imem_m[0] = enc(3, 3, 1, 0);
        imem_m[1] = enc(0, 0, 3, 3);
        use_fixed_rx = 1; fixed_rx = 32'h0005_0006;
        run_case(2, 1, 0, 0, 1, 32'h000A_000C, 3, 5);
        run_case(2, 1, 0, 0, 1, 32'h000A_000C, 0, 0);
        use_fixed_rx = 0;

        // start with empty program is ignored
        do_reset();
        bus.start = 1'b1; bus.iter_num = 8'd3; tick();
        bus.start = 1'b0; tick(); tick();
        chk("empty_prog_busy", {31'b0, bus.busy}, 32'd0);

        // 17 loads (last ignored), iter_num=0 start ignored, loads/start while busy ignored
        rand_rf();
        for (int i = 0; i < 17; i++)
            imem_m[i] = enc($urandom_range(0, 2), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        imem_m[3] = enc(3, 0, 5, 0);
        run_case(17, 2, 1, 1, 0, 32'd0, 1, 2);

        // Reset during XFER, empty-program start afterwards, then reload and rerun
        do_reset();
        rand_rf();
        imem_m[0] = enc(3, 2, 1, 0);
        imem_m[1] = enc(0, 0, 2, 1);
        tx_hold = 30; rx_hold = 30;
        launch(2, 1, 0, 0, 0, 32'd0, cost);
        tick(); tick(); tick();
        chk("xfer_tx_v", {31'b0, bus.dout_tx_v}, 32'd1);
        do_reset();
        bus.start = 1'b1; bus.iter_num = 8'd1; tick();
        bus.start = 1'b0; tick();
        chk("post_rst_busy", {31'b0, bus.busy}, 32'd0);
        tx_hold = 1; rx_hold = 2;
        rand_rf();
        launch(2, 1, 0, 0, 0, 32'd0, cost);
        await_done(cost);

        // Random programs
        for (int n = 0; n < 15; n++) begin
            int plen;
            rand_rf();
            plen = $urandom_range(1, 8);
            for (int i = 0; i < plen; i++)
                imem_m[i] = enc($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            run_case(plen, $urandom_range(1, 4), 0, 1'($urandom_range(0, 1)), 0, 32'd0,
                     $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
